// File: rtl/i2c_target_regfile.sv
// I2C target exposing a pointer-addressed byte register window to a host register bank.
// SDA/SCL are oversampled on the system clock; no logic runs on SCL.
module i2c_target_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int PTR_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sda_in,
  input  logic             i_scl_in,
  input  logic [6:0]       i_slave_addr,
  output logic             o_sda_out,
  output logic             o_sda_en,
  output logic             o_wr_stb,
  output logic [PTR_W-1:0] o_wr_idx,
  output logic [7:0]       o_wr_data,
  output logic [PTR_W-1:0] o_rd_idx,
  input  logic [7:0]       i_rd_data,
  output logic             o_busy,
  output logic             o_error,
  output logic [3:0]       o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sda_sync, r_scl_sync;
  logic r_sda_d, r_scl_d;
  logic r_start, r_stop, r_scl_rise, r_scl_fall;
  logic w_sda, w_scl;

  state_t           r_state, w_state_n;
  logic [3:0]       r_cnt, w_cnt_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [PTR_W-1:0] r_ptr, w_ptr_n, w_ptr_inc;
  logic             r_sda_en, w_sda_en_n;
  logic             r_busy, w_busy_n;
  logic             r_rw, w_rw_n;
  logic             r_mack, w_mack_n;
  logic             r_wr_stb, w_wr_stb_n;
  logic [PTR_W-1:0] r_wr_idx, w_wr_idx_n;
  logic [7:0]       r_wr_data, w_wr_data_n;
  logic             r_error, w_error_n;
  logic             w_byte_done, w_ptr_ok, w_rx_state;

  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign w_scl = r_scl_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sda_sync <= '1;
      r_scl_sync <= '1;
      r_sda_d    <= 1'b1;
      r_scl_d    <= 1'b1;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
    end else begin
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda_in};
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl_in};
      r_sda_d    <= w_sda;
      r_scl_d    <= w_scl;
      r_start    <= r_sda_d & ~w_sda & r_scl_d & w_scl;
      r_stop     <= ~r_sda_d & w_sda & r_scl_d & w_scl;
      r_scl_rise <= ~r_scl_d & w_scl;
      r_scl_fall <= r_scl_d & ~w_scl;
    end
  end

  // r_cnt counts SCL rises, so a START/STOP arriving on the rise of bit k sees r_cnt=k;
  // r_cnt>=2 therefore means at least one whole bit of the byte was already clocked in.
  assign w_byte_done = r_scl_fall && (r_cnt == 4'd8);
  assign w_ptr_ok    = ({1'b0, r_shift} < 9'(NUM_REGS));
  assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);
  assign w_rx_state  = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WDATA);

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shift_n   = r_shift;
    w_ptr_n     = r_ptr;
    w_sda_en_n  = r_sda_en;
    w_busy_n    = r_busy;
    w_rw_n      = r_rw;
    w_mack_n    = r_mack;
    w_wr_stb_n  = 1'b0;
    w_wr_idx_n  = r_wr_idx;
    w_wr_data_n = r_wr_data;
    w_error_n   = 1'b0;
    if (r_start || r_stop) begin
      w_state_n  = r_start ? S_ADDR : S_IDLE;
      w_cnt_n    = '0;
      w_sda_en_n = 1'b0;
      w_busy_n   = 1'b0;
      if ((r_state == S_PTR || r_state == S_WDATA) && r_cnt >= 4'd2) w_error_n = 1'b1;
    end else begin
      if (r_scl_rise && w_rx_state) begin
        w_shift_n = {r_shift[6:0], r_sda_d};
        w_cnt_n   = r_cnt + 4'd1;
      end
      case (r_state)
        S_ADDR: if (w_byte_done) begin
          w_cnt_n = '0;
          if (r_shift[7:1] == i_slave_addr) begin
            w_state_n  = S_ADDR_ACK;
            w_sda_en_n = 1'b1;
            w_busy_n   = 1'b1;
            w_rw_n     = r_shift[0];
          end else begin
            w_state_n = S_WAIT_STOP;
          end
        end
        S_ADDR_ACK: if (r_scl_fall) begin
          w_cnt_n = '0;
          if (r_rw) begin
            w_state_n  = S_TX;
            w_shift_n  = i_rd_data;
            w_sda_en_n = ~i_rd_data[7];
          end else begin
            w_state_n  = S_PTR;
            w_sda_en_n = 1'b0;
          end
        end
        S_PTR: if (w_byte_done) begin
          w_cnt_n = '0;
          if (w_ptr_ok) begin
            w_ptr_n    = r_shift[PTR_W-1:0];
            w_sda_en_n = 1'b1;
            w_state_n  = S_PTR_ACK;
          end else begin
            w_error_n = 1'b1;
            w_state_n = S_WAIT_STOP;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: if (r_scl_fall) begin
          w_sda_en_n = 1'b0;
          w_cnt_n    = '0;
          w_state_n  = S_WDATA;
        end
        S_WDATA: if (w_byte_done) begin
          w_cnt_n     = '0;
          w_wr_stb_n  = 1'b1;
          w_wr_idx_n  = r_ptr;
          w_wr_data_n = r_shift;
          w_ptr_n     = w_ptr_inc;
          w_sda_en_n  = 1'b1;
          w_state_n   = S_WDATA_ACK;
        end
        S_TX: if (r_scl_fall) begin
          if (r_cnt == 4'd7) begin
            w_sda_en_n = 1'b0;
            w_cnt_n    = '0;
            w_state_n  = S_TX_ACK;
          end else begin
            w_shift_n  = {r_shift[6:0], 1'b0};
            w_sda_en_n = ~r_shift[6];
            w_cnt_n    = r_cnt + 4'd1;
          end
        end
        // Pointer advances on the master's ACK so rd_idx already names the next byte at reload.
        S_TX_ACK: begin
          if (r_scl_rise) begin
            w_mack_n = r_sda_d;
            if (!r_sda_d) w_ptr_n = w_ptr_inc;
          end else if (r_scl_fall) begin
            if (!r_mack) begin
              w_state_n  = S_TX;
              w_shift_n  = i_rd_data;
              w_sda_en_n = ~i_rd_data[7];
              w_cnt_n    = '0;
            end else begin
              w_state_n = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_shift   <= w_shift_n;
      r_ptr     <= w_ptr_n;
      r_sda_en  <= w_sda_en_n;
      r_busy    <= w_busy_n;
      r_rw      <= w_rw_n;
      r_mack    <= w_mack_n;
      r_wr_stb  <= w_wr_stb_n;
      r_wr_idx  <= w_wr_idx_n;
      r_wr_data <= w_wr_data_n;
      r_error   <= w_error_n;
    end
  end

  assign o_sda_en    = r_sda_en;
  assign o_sda_out   = ~r_sda_en;
  assign o_wr_stb    = r_wr_stb;
  assign o_wr_idx    = r_wr_idx;
  assign o_wr_data   = r_wr_data;
  assign o_rd_idx    = r_ptr;
  assign o_busy      = r_busy;
  assign o_error     = r_error;
  assign o_dbg_state = r_state;

endmodule
